seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module   : seq_divider
// Brief    : Radix-2 restoring sequential divider, fixed WIDTH-cycle latency.
//            Optional divide-by-zero flag output enabled by SEQ_DIV_ZERO_ERR_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_ZERO_ERR_EN
    ,
    output logic             div_err
`endif
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // r_dvd starts as the dividend and fills with quotient bits from the LSB.
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [c_CW-1:0]  r_cnt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_last;
    logic             w_accept;

    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    // With the shifted top bit clear both operands are below 2^WIDTH, so the
    // top bit of the difference is the borrow; with it set the trial always fits.
    assign w_ge       = w_shift[WIDTH] | ~w_diff[WIDTH];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_dvd[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == c_LAST);
    assign w_accept   = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIV_ZERO_ERR_EN
            div_err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_dvd <= dividend;
                r_dvs <= divisor;
                r_rem <= '0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_dvd <= w_quo_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    quotient  <= w_quo_next;
                    remainder <= w_rem_next;
                    done      <= 1'b1;
`ifdef SEQ_DIV_ZERO_ERR_EN
                    div_err   <= (r_dvs == '0);
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_divider
// Brief    : Self-checking bench for seq_divider (WIDTH=64) against an
//            arithmetic reference; covers div_err when SEQ_DIV_ZERO_ERR_EN is set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

    localparam int c_W = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [c_W-1:0] dividend;
    logic [c_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
`ifdef SEQ_DIV_ZERO_ERR_EN
    logic           div_err;
`endif

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef SEQ_DIV_ZERO_ERR_EN
        ,
        .div_err   (div_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic ref_div(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                           output logic [c_W-1:0] q, output logic [c_W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Present operands with start for exactly one rising edge (edge k).
    task automatic launch(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after edge k until done; optionally pulse a stray start.
    task automatic wait_done(input string tag, input int inject_at);
        logic [c_W-1:0] q0;
        logic [c_W-1:0] r0;
        bit             stable;
        bit             busy_ok;
        int             lat;
        q0      = quotient;
        r0      = remainder;
        stable  = 1'b1;
        busy_ok = 1'b1;
        lat     = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (quotient !== q0 || remainder !== r0) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == inject_at) begin
                dividend = 64'd100;
                divisor  = 64'd3;
                start    = 1'b1;
            end else if (n == inject_at + 1) begin
                start = 1'b0;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd64);
        check({tag, " outputs held during run"}, 64'(stable), 64'd1);
        check({tag, " busy during run"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        logic [c_W-1:0] eq;
        logic [c_W-1:0] er;
        ref_div(a, b, eq, er);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
`ifdef SEQ_DIV_ZERO_ERR_EN
        check({tag, " div_err"}, 64'(div_err), 64'(b == '0));
`endif
    endtask

    task automatic run_check(input string tag, input logic [c_W-1:0] a,
                             input logic [c_W-1:0] b, input int inject_at);
        logic [c_W-1:0] q1;
        launch(a, b);
        wait_done(tag, inject_at);
        check_result(tag, a, b);
        q1 = quotient;
        @(posedge clk);
        #1;
        check({tag, " single done pulse"}, 64'(done), 64'd0);
        check({tag, " idle after done"}, 64'(busy), 64'd0);
        check({tag, " quotient held"}, quotient, q1);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        bit quiet;
        quiet = 1'b1;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check({tag, " no further activity"}, 64'(quiet), 64'd1);
    endtask

    initial begin
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset quotient", quotient, 64'd0);
        check("reset remainder", remainder, 64'd0);
`ifdef SEQ_DIV_ZERO_ERR_EN
        check("reset div_err", 64'(div_err), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_check("basic", 64'd65478898, 64'd1023, -100);
        check("basic quotient const", quotient, 64'd64006);
        check("basic remainder const", remainder, 64'd760);
        run_check("equal", 64'd1023, 64'd1023, -100);
        run_check("small", 64'd5, 64'd1023, -100);
        run_check("max by one", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, -100);
        run_check("max by max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -100);
        run_check("max by two", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, -100);
        run_check("div zero", 64'd7, 64'd0, -100);
        check("div zero quotient const", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("div zero remainder const", remainder, 64'd7);

        // Stray start in the middle of a run must not disturb it.
        run_check("busy start", 64'd65478898, 64'd1023, 10);
        watch_quiet("busy start", 80);

        // Start held high across DONE is taken in the first IDLE cycle.
        @(negedge clk);
        dividend = 64'd123456789;
        divisor  = 64'd97;
        start    = 1'b1;
        @(posedge clk);
        #1;
        wait_done("b2b first", -100);
        check_result("b2b first", 64'd123456789, 64'd97);
        dividend = 64'd1000000;
        divisor  = 64'd7;
        @(posedge clk);
        #1;
        check("b2b idle gap", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("b2b reaccept", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done("b2b second", -100);
        check_result("b2b second", 64'd1000000, 64'd7);

        // Asynchronous reset in the middle of a run aborts it.
        launch(64'd65478898, 64'd1023);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort quotient", quotient, 64'd0);
        check("abort remainder", remainder, 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("abort", 80);
        run_check("after abort", 64'd1023, 64'd1023, -100);

        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       b = {$urandom, $urandom};
                1:       b = 64'($urandom_range(1, 65535));
                2:       b = 64'($urandom_range(1, 7));
                3:       b = a + 64'($urandom_range(1, 1000));
                default: b = {32'd0, $urandom};
            endcase
            if (i == 11) b = '0;
            if (i == 17) a = 64'($urandom_range(0, 1000));
            run_check("random", a, b, (i % 3 == 0) ? int'($urandom_range(1, 60)) : -100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
